// File: rtl/bit_count_pkg.sv
// ============================================================================
// Module   : bit_count_pkg
// Purpose  : Shared types for the sequential bit-counting engine: the
//            controller state encoding, the operation-mode encoding, and a
//            helper that folds the reserved mode onto popcount.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_POP = 2'b00,
    MODE_LZC = 2'b01,
    MODE_TZC = 2'b10
  } mode_t;

  // The reserved encoding 2'b11 behaves exactly like popcount.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'b01:   m = MODE_LZC;
      2'b10:   m = MODE_TZC;
      default: m = MODE_POP;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_count_if.sv
// ============================================================================
// Module   : bit_count_if
// Purpose  : Request/response bundle between a requester and bit_count_unit.
// Ports    : start/mode/data  requester -> unit (sampled while rdy=1)
//            rdy/done/count/zero  unit -> requester
//            master modport = requester side, slave modport = unit side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_count_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) ();

  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data;
  logic              rdy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              zero;

  modport master (
    output start, mode, data,
    input  rdy, done, count, zero
  );

  modport slave (
    input  start, mode, data,
    output rdy, done, count, zero
  );

endinterface

`default_nettype wire

// File: rtl/bit_count_dp.sv
// ============================================================================
// Module   : bit_count_dp
// Purpose  : Datapath of the bit-counting engine. Holds the operand shift
//            register, the running count, the all-zero flag and the latched
//            mode, and reports the termination flags to the controller.
// Ports    : clk, rstb (async active-low)
//            load, shift, incr   control strobes from the controller
//            data_in, mode_in    operand and raw mode, captured on load
//            mode_q              latched (decoded) mode
//            count, zero         result registers
//            r1_zero, r1_msb     termination flags of the shift register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_count_dp
  import bit_count_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  wire logic              clk,
  input  wire logic              rstb,
  input  wire logic              load,
  input  wire logic              shift,
  input  wire logic              incr,
  input  wire logic [DATA_W-1:0] data_in,
  input  wire logic [1:0]        mode_in,
  output mode_t                  mode_q,
  output logic      [CNT_W-1:0]  count,
  output logic                   zero,
  output logic                   r1_zero,
  output logic                   r1_msb
);

  logic [DATA_W-1:0] r1;
  logic [DATA_W-1:0] data_rev;
  mode_t             mode_dec;
  logic              data_is_zero;

  // TZC scans the reversed operand so the same MSB-first walk counts
  // trailing zeros.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign data_rev[i] = data_in[DATA_W-1-i];
  end

  assign mode_dec     = decode_mode(mode_in);
  assign data_is_zero = (data_in == '0);
  assign r1_zero      = (r1 == '0);
  assign r1_msb       = r1[DATA_W-1];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r1     <= '0;
      count  <= '0;
      zero   <= 1'b0;
      mode_q <= MODE_POP;
    end else if (load) begin
      mode_q <= mode_dec;
      r1     <= (mode_dec == MODE_TZC) ? data_rev : data_in;
      zero   <= data_is_zero;
      // A zero operand has no set bit to stop on, so zero-counts are
      // resolved to full width up front.
      count  <= (data_is_zero && mode_dec != MODE_POP) ? CNT_W'(DATA_W) : '0;
    end else begin
      if (shift) r1    <= {r1[DATA_W-2:0], 1'b0};
      if (incr)  count <= count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit_count_unit.sv
// ============================================================================
// Module   : bit_count_unit
// Purpose  : Multi-cycle bit-counting coprocessor: popcount, leading-zero
//            count and trailing-zero count, scanning one bit per cycle with
//            early termination. Contains the IDLE/SCAN/DONE controller and
//            instantiates the datapath bit_count_dp.
// Ports    : clk            clock, rising edge
//            rstb           asynchronous active-low reset
//            bus (slave)    start/mode/data in, rdy/done/count/zero out
//            parity         only when BIT_COUNT_PARITY_EN is defined:
//                           count[0] in popcount mode, 0 otherwise
// Config   : BIT_COUNT_PARITY_EN - adds the parity output
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_count_unit
  import bit_count_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  wire logic   clk,
  input  wire logic   rstb,
  bit_count_if.slave  bus
`ifdef BIT_COUNT_PARITY_EN
  ,
  output logic        parity
`endif
);

  state_t            state, state_nxt;
  mode_t             mode_q;
  logic              load, shift, incr;
  logic              r1_zero, r1_msb;
  logic              scan_end;
  logic [CNT_W-1:0]  count;
  logic              zero;

  // Popcount only stops once no set bits remain; the zero-counts also stop
  // at the first set bit reaching the MSB.
  assign scan_end = r1_zero || (mode_q != MODE_POP && r1_msb);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    incr      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (scan_end) begin
          state_nxt = DONE;
        end else begin
          shift = 1'b1;
          incr  = (mode_q == MODE_POP) ? r1_msb : 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  bit_count_dp #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_dp (
    .clk     (clk),
    .rstb    (rstb),
    .load    (load),
    .shift   (shift),
    .incr    (incr),
    .data_in (bus.data),
    .mode_in (bus.mode),
    .mode_q  (mode_q),
    .count   (count),
    .zero    (zero),
    .r1_zero (r1_zero),
    .r1_msb  (r1_msb)
  );

  assign bus.rdy   = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.count = count;
  assign bus.zero  = zero;

`ifdef BIT_COUNT_PARITY_EN
  // Follows count, so it is held and reset exactly like count.
  assign parity = (mode_q == MODE_POP) && count[0];
`endif

endmodule

`default_nettype wire
